digit_entry: RTL and testbench

Keypad digit-entry controller for the calculator datapath. Collects decimal digit presses and operator keys into two 2-digit BCD operands plus an operation code, and presents the four BCD digits (operand-1 tens/ones, operand-2 tens/ones) to the `adjust` stage. `adjust` converts them to binary operands. Sits between the debounced keypad decoder and `adjust`/ALU.

---
 rtl/calc_pkg.sv | 24 ++
 rtl/bcd_shift2.sv | 31 +++
 rtl/digit_entry.sv | 124 ++++++++++++
 tb/tb_digit_entry.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator types: keypad codes, ALU operation codes and digit-entry states.
package calc_pkg;

   localparam logic [3:0] KEY_ADD    = 4'd10;
   localparam logic [3:0] KEY_SUB    = 4'd11;
   localparam logic [3:0] KEY_MUL    = 4'd12;
   localparam logic [3:0] KEY_DIV    = 4'd13;
   localparam logic [3:0] KEY_CLEAR  = 4'd14;
   localparam logic [3:0] KEY_EQUALS = 4'd15;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      S_OP1   = 2'd0,
      S_OP2   = 2'd1,
      S_READY = 2'd2
   } entry_state_t;

endpackage

// File: rtl/bcd_shift2.sv
// Two-digit BCD shift register: new digits enter the ones slot, count saturates at 2.
module bcd_shift2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       load,
   input  logic       shift,
   input  logic [3:0] digit,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic [1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         tens <= 4'd0;
         ones <= 4'd0;
         cnt  <= 2'd0;
      end else if (load) begin
         tens <= 4'd0;
         ones <= digit;
         cnt  <= 2'd1;
      end else if (shift && (cnt < 2'd2)) begin
         // a third digit falls through here untouched
         tens <= ones;
         ones <= digit;
         cnt  <= cnt + 2'd1;
      end
   end

endmodule

// File: rtl/digit_entry.sv
// Keypad digit-entry controller: builds two 2-digit BCD operands and an op code.
//   state   | meaning
//   S_OP1   | entering operand 1
//   S_OP2   | entering operand 2 (op may still be replaced until a digit arrives)
//   S_READY | expression complete, everything held
module digit_entry
   import calc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic [3:0] a,
   output logic [3:0] b,
   output logic [3:0] c,
   output logic [3:0] d,
   output logic [1:0] op,
   output logic       ready,
   output logic       go
);

   entry_state_t state_q, state_d;
   op_t          op_q, op_d;
   logic         go_d;
   logic         clr1, clr2, load1, shift1, shift2;
   logic [1:0]   cnt1, cnt2;
   logic         is_digit, is_oper;
   logic [3:0]   key_rel;
   op_t          key_op;

   assign is_digit = (key_code <= 4'd9);
   assign is_oper  = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
   assign key_rel  = key_code - KEY_ADD;
   assign key_op   = op_t'(key_rel[1:0]);

   bcd_shift2 u_opnd1 (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr1),
      .load  (load1),
      .shift (shift1),
      .digit (key_code),
      .tens  (a),
      .ones  (b),
      .cnt   (cnt1)
   );

   bcd_shift2 u_opnd2 (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr2),
      .load  (1'b0),
      .shift (shift2),
      .digit (key_code),
      .tens  (c),
      .ones  (d),
      .cnt   (cnt2)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_OP1;
         op_q    <= OP_ADD;
         go      <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         go      <= go_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      clr1    = 1'b0;
      clr2    = 1'b0;
      load1   = 1'b0;
      shift1  = 1'b0;
      shift2  = 1'b0;
      if (key_valid) begin
         if (key_code == KEY_CLEAR) begin
            clr1    = 1'b1;
            clr2    = 1'b1;
            op_d    = OP_ADD;
            state_d = S_OP1;
         end else begin
            case (state_q)
               S_OP1: begin
                  if (is_digit) begin
                     shift1 = 1'b1;
                  end else if (is_oper && (cnt1 != 2'd0)) begin
                     op_d    = key_op;
                     state_d = S_OP2;
                  end
               end
               S_OP2: begin
                  if (is_digit) begin
                     shift2 = 1'b1;
                  end else if (is_oper && (cnt2 == 2'd0)) begin
                     op_d = key_op;
                  end else if ((key_code == KEY_EQUALS) && (cnt2 != 2'd0)) begin
                     state_d = S_READY;
                  end
               end
               S_READY: begin
                  // a fresh digit starts a new expression with it as operand 1
                  if (is_digit) begin
                     load1   = 1'b1;
                     clr2    = 1'b1;
                     op_d    = OP_ADD;
                     state_d = S_OP1;
                  end
               end
               default: state_d = S_OP1;
            endcase
         end
      end
      go_d = (state_d == S_READY) && (state_q != S_READY);
   end

   assign op    = op_q;
   assign ready = (state_q == S_READY);

endmodule

// File: tb/tb_digit_entry.sv
// Self-checking bench for digit_entry: directed scenarios plus randomized keys against a value-level model.
module tb_digit_entry;
   import calc_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'd0;
   logic [3:0] a, b, c, d;
   logic [1:0] op;
   logic       ready, go;

   int checks = 0;
   int errors = 0;

   // model: operands kept as plain numbers, mode 0/1/2 = operand1/operand2/complete
   int m_mode, m_n1, m_n2, m_c1, m_c2, m_op;
   bit m_go;

   logic [19:0] obs, exp_v;
   assign obs = {a, b, c, d, op, ready, go};

   digit_entry dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_code  (key_code),
      .a         (a),
      .b         (b),
      .c         (c),
      .d         (d),
      .op        (op),
      .ready     (ready),
      .go        (go)
   );

   always #5 clk = ~clk;

   function automatic logic [19:0] vec(int ta, int tb, int tc, int td, int top, bit rdy, bit g);
      logic [3:0] va, vb, vc, vd;
      logic [1:0] vo;
      va = 4'(ta); vb = 4'(tb); vc = 4'(tc); vd = 4'(td); vo = 2'(top);
      return {va, vb, vc, vd, vo, rdy, g};
   endfunction

   function automatic logic [19:0] model_vec();
      return vec(m_n1 / 10, m_n1 % 10, m_n2 / 10, m_n2 % 10, m_op, m_mode == 2, m_go);
   endfunction

   task automatic model_apply(input bit r, input bit v, input int k);
      bit was_ready;
      was_ready = (m_mode == 2);
      if (r) begin
         m_mode = 0; m_n1 = 0; m_n2 = 0; m_c1 = 0; m_c2 = 0; m_op = 0; m_go = 0;
         return;
      end
      if (v) begin
         if (k == 14) begin
            m_mode = 0; m_n1 = 0; m_n2 = 0; m_c1 = 0; m_c2 = 0; m_op = 0;
         end else if (k <= 9) begin
            if (m_mode == 0 && m_c1 < 2) begin
               m_n1 = m_n1 * 10 + k; m_c1++;
            end else if (m_mode == 1 && m_c2 < 2) begin
               m_n2 = m_n2 * 10 + k; m_c2++;
            end else if (m_mode == 2) begin
               m_n1 = k; m_c1 = 1; m_n2 = 0; m_c2 = 0; m_op = 0; m_mode = 0;
            end
         end else if (k == 15) begin
            if (m_mode == 1 && m_c2 > 0) m_mode = 2;
         end else begin
            if (m_mode == 0 && m_c1 > 0) begin
               m_op = k - 10; m_mode = 1;
            end else if (m_mode == 1 && m_c2 == 0) begin
               m_op = k - 10;
            end
         end
      end
      m_go = (m_mode == 2) && !was_ready;
   endtask

   task automatic step(input bit r, input bit v, input int k);
      @(negedge clk);
      rst = r; key_valid = v; key_code = 4'(k);
      @(posedge clk);
      #1;
      model_apply(r, v, k);
   endtask

   task automatic test_reset();
      step(1, 0, 0);
      step(1, 0, 0);
      exp_v = vec(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reset: got %h exp %h", obs, exp_v); end
      step(1, 1, 5);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reset_vs_key: got %h exp %h", obs, exp_v); end
      step(0, 0, 0);
      checks++;
      if (dut.state_q !== S_OP1) begin errors++; $display("FAIL reset_state: got %0d exp %0d", dut.state_q, S_OP1); end
   endtask

   task automatic test_basic();
      int seq[5] = '{4, 2, 10, 1, 7};
      step(1, 0, 0);
      foreach (seq[i]) step(0, 1, seq[i]);
      step(0, 1, 15);
      exp_v = vec(4, 2, 1, 7, 0, 1, 1);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL basic_go: got %h exp %h", obs, exp_v); end
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 0);
         exp_v = vec(4, 2, 1, 7, 0, 1, 0);
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL basic_hold%0d: got %h exp %h", i, obs, exp_v); end
      end
   endtask

   task automatic test_ready_restart();
      step(0, 1, 3);
      exp_v = vec(0, 3, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL ready_digit: got %h exp %h", obs, exp_v); end
      step(0, 1, 15);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL ready_equals_ignored: got %h exp %h", obs, exp_v); end
   endtask

   task automatic test_sub_and_overflow();
      int seq[4] = '{5, 11, 9, 15};
      step(1, 0, 0);
      foreach (seq[i]) step(0, 1, seq[i]);
      exp_v = vec(0, 5, 0, 9, 1, 1, 1);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL sub_expr: got %h exp %h", obs, exp_v); end
      step(1, 0, 0);
      step(0, 1, 1); step(0, 1, 2); step(0, 1, 3);
      exp_v = vec(1, 2, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL third_digit: got %h exp %h", obs, exp_v); end
      step(1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 7);
      exp_v = vec(7, 7, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL held_key: got %h exp %h", obs, exp_v); end
   endtask

   task automatic test_ignore();
      int seq[4] = '{6, 12, 13, 15};
      bit go_seen = 0;
      step(1, 0, 0);
      step(0, 1, 10);
      checks++;
      if (dut.state_q !== S_OP1 || obs !== vec(0, 0, 0, 0, 0, 0, 0)) begin
         errors++; $display("FAIL op_no_digits: got state %0d out %h", dut.state_q, obs);
      end
      foreach (seq[i]) begin
         step(0, 1, seq[i]);
         if (go === 1'b1) go_seen = 1;
      end
      checks++;
      if (op !== 2'd3 || dut.state_q !== S_OP2 || go_seen) begin
         errors++; $display("FAIL op_replace: got op %0d state %0d go_seen %0d exp 3 %0d 0", op, dut.state_q, go_seen, S_OP2);
      end
      step(0, 1, 8); step(0, 1, 10);
      exp_v = vec(0, 6, 0, 8, 3, 0, 0);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL op_locked: got %h exp %h", obs, exp_v); end
   endtask

   task automatic test_clear();
      int seq[4] = '{9, 9, 12, 4};
      int seq2[4] = '{2, 13, 1, 15};
      step(1, 0, 0);
      foreach (seq[i]) step(0, 1, seq[i]);
      step(0, 1, 14);
      exp_v = vec(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== exp_v || dut.state_q !== S_OP1) begin
         errors++; $display("FAIL clear: got %h state %0d exp %h state %0d", obs, dut.state_q, exp_v, S_OP1);
      end
      foreach (seq2[i]) step(0, 1, seq2[i]);
      exp_v = vec(0, 2, 0, 1, 3, 1, 1);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL after_clear: got %h exp %h", obs, exp_v); end
   endtask

   task automatic test_random();
      int k;
      bit r, v;
      step(1, 0, 0);
      for (int n = 0; n < 1500; n++) begin
         r = ($urandom_range(0, 99) < 2);
         v = ($urandom_range(0, 99) < 75);
         // weight toward digits and EQUALS so expressions actually complete
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: k = $urandom_range(0, 9);
            5, 6:          k = $urandom_range(10, 13);
            7, 8:          k = 15;
            default:       k = $urandom_range(0, 15);
         endcase
         step(r, v, k);
         exp_v = model_vec();
         checks++;
         if (obs !== exp_v) begin
            errors++; $display("FAIL random[%0d] key %0d v %0d r %0d: got %h exp %h", n, k, v, r, obs, exp_v);
         end
      end
   endtask

   initial begin
      model_apply(1, 0, 0);
      test_reset();
      test_basic();
      test_ready_restart();
      test_sub_and_overflow();
      test_ignore();
      test_clear();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
